// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next control-ROM address from the current
// control word, condition inputs and a 4-deep return stack for microsubroutines.
module microsequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rom_word,
    input  logic [7:0]  enc_state,
    input  logic [7:0]  cond,
    input  logic        halt,
    output logic [7:0]  state,
    output logic [2:0]  depth,
    output logic        ovf,
    output logic        unf
);

    localparam int unsigned STACK_DEPTH = 4;

    logic [7:0] r_state;
    logic [2:0] r_depth;
    logic       r_ovf;
    logic       r_unf;
    logic [7:0] r_stack [STACK_DEPTH];

    logic [2:0] w_n;
    logic       w_inv;
    logic [2:0] w_s;
    logic [7:0] w_crh;
    logic [7:0] w_crl;
    logic       w_c;
    logic [7:0] w_inc;
    logic [1:0] w_top_idx;
    logic [7:0] w_top;
    logic [7:0] w_next;
    logic       w_push;
    logic       w_pop;
    logic       w_ovf_set;
    logic       w_unf_set;
    logic       w_unused;

    assign w_n      = rom_word[56:54];
    assign w_inv    = rom_word[53];
    assign w_s      = rom_word[50:48];
    assign w_crh    = rom_word[15:8];
    assign w_crl    = rom_word[7:0];
    assign w_unused = ^{rom_word[63:57], rom_word[52:51], rom_word[47:16]};

    assign w_c   = cond[w_s] ^ w_inv;
    assign w_inc = r_state + 8'd1;

    // Low two bits of depth-1 address the top entry for depth 1..4.
    assign w_top_idx = r_depth[1:0] - 2'd1;
    assign w_top     = r_stack[w_top_idx];

    always_comb begin
        w_next    = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (w_n)
            3'b000: w_next = 8'd1;
            3'b001: w_next = w_c ? w_crh : w_crl;
            3'b010: w_next = w_crl;
            3'b011: w_next = w_inc;
            3'b100: w_next = enc_state;
            3'b101: w_next = w_c ? w_crl : w_inc;
            3'b110: begin
                w_next = w_crl;
                if (r_depth == 3'(STACK_DEPTH)) w_ovf_set = 1'b1;
                else                            w_push    = 1'b1;
            end
            default: begin
                if (r_depth == 3'd0) begin
                    w_next    = 8'd1;
                    w_unf_set = 1'b1;
                end else begin
                    w_next = w_top;
                    w_pop  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else if (!halt) begin
            r_state <= w_next;
            if (w_push) begin
                r_stack[r_depth[1:0]] <= w_inc;
                r_depth               <= r_depth + 3'd1;
            end else if (w_pop) begin
                r_depth <= r_depth - 3'd1;
            end
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
        end
    end

    assign state = r_state;
    assign depth = r_depth;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: expected {state,depth,ovf,unf} is queued
// as each control word is applied and compared one clock edge later.
module tb_microsequencer;

    logic        clk;
    logic        reset;
    logic [63:0] rom_word;
    logic [7:0]  enc_state;
    logic [7:0]  cond;
    logic        halt;
    logic [7:0]  state;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [12:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];

    microsequencer dut (
        .clk       (clk),
        .reset     (reset),
        .rom_word  (rom_word),
        .enc_state (enc_state),
        .cond      (cond),
        .halt      (halt),
        .state     (state),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Control word with random filler in every field the sequencer must ignore.
    function automatic logic [63:0] mkw(input logic [2:0] n, input logic inv,
                                        input logic [2:0] s, input logic [7:0] crh,
                                        input logic [7:0] crl);
        logic [63:0] w;
        w        = {$urandom, $urandom};
        w[56:54] = n;
        w[53]    = inv;
        w[50:48] = s;
        w[15:8]  = crh;
        w[7:0]   = crl;
        return w;
    endfunction

    function automatic logic [12:0] ex(input logic [7:0] st, input logic [2:0] d,
                                       input logic o, input logic u);
        return {st, d, o, u};
    endfunction

    task automatic drive(input logic [63:0] w, input logic [7:0] c, input logic [7:0] e,
                         input logic h, input logic r, input logic [12:0] x,
                         input string nm);
        exp_t item;
        rom_word  = w;
        cond      = c;
        enc_state = e;
        halt      = h;
        reset     = r;
        item.v    = x;
        item.name = nm;
        sb.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(mkw(3'b000, 1'b0, 3'd0, 8'h00, 8'h00), 8'($urandom), 8'($urandom),
                  1'b0, (i < 2), (i < 2) ? ex(8'h00, 3'd0, 1'b0, 1'b0) : ex(8'h01, 3'd0, 1'b0, 1'b0),
                  "reset_release");
            e = sb.pop_front();
            checks++;
            if ({state, depth, ovf, unf} !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got {st,d,o,u}=%h want %h", e.name, i,
                         {state, depth, ovf, unf}, e.v);
            end
        end
    endtask

    task automatic test_moc_wait();
        exp_t e;
        drive(mkw(3'b010, 1'b0, 3'd0, 8'h00, 8'h03), 8'($urandom), 8'($urandom),
              1'b0, 1'b0, ex(8'h03, 3'd0, 1'b0, 1'b0), "jump_to_3");
        e = sb.pop_front();
        checks++;
        if ({state, depth, ovf, unf} !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, {state, depth, ovf, unf}, e.v);
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c;
            c    = 8'($urandom);
            c[0] = (i == 3);
            drive(mkw(3'b101, 1'b1, 3'd0, 8'($urandom), 8'h03), c, 8'($urandom),
                  1'b0, 1'b0, (i < 3) ? ex(8'h03, 3'd0, 1'b0, 1'b0) : ex(8'h04, 3'd0, 1'b0, 1'b0),
                  "moc_wait");
            e = sb.pop_front();
            checks++;
            if ({state, depth, ovf, unf} !== e.v) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h want %h", e.name, i,
                         {state, depth, ovf, unf}, e.v);
            end
        end
    endtask

    task automatic test_dispatch_wrap();
        exp_t        e;
        logic [63:0] w  [6];
        logic [7:0]  c  [6];
        logic [7:0]  xs [6];
        w[0] = mkw(3'b100, 1'b0, 3'd0, 8'h00, 8'h00); c[0] = 8'($urandom); xs[0] = 8'h2A;
        w[1] = mkw(3'b010, 1'b0, 3'd0, 8'h00, 8'hFF); c[1] = 8'($urandom); xs[1] = 8'hFF;
        w[2] = mkw(3'b011, 1'b0, 3'd0, 8'h00, 8'h00); c[2] = 8'($urandom); xs[2] = 8'h00;
        w[3] = mkw(3'b000, 1'b0, 3'd0, 8'h00, 8'h00); c[3] = 8'($urandom); xs[3] = 8'h01;
        w[4] = mkw(3'b101, 1'b0, 3'd1, 8'h00, 8'h77); c[4] = 8'b0000_0000; xs[4] = 8'h02;
        w[5] = mkw(3'b101, 1'b0, 3'd1, 8'h00, 8'h77); c[5] = 8'b0000_0010; xs[5] = 8'h77;
        for (int i = 0; i < 6; i++) begin
            drive(w[i], c[i], (i == 0) ? 8'h2A : 8'($urandom), 1'b0, 1'b0,
                  ex(xs[i], 3'd0, 1'b0, 1'b0), "dispatch_wrap");
            e = sb.pop_front();
            checks++;
            if ({state, depth, ovf, unf} !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i,
                         {state, depth, ovf, unf}, e.v);
            end
        end
    endtask

    task automatic test_two_way();
        exp_t        e;
        logic [63:0] w  [5];
        logic [7:0]  c  [5];
        logic [7:0]  xs [5];
        w[0] = mkw(3'b001, 1'b0, 3'd1, 8'h40, 8'h50); c[0] = 8'h02; xs[0] = 8'h40;
        w[1] = mkw(3'b001, 1'b1, 3'd1, 8'h40, 8'h50); c[1] = 8'h02; xs[1] = 8'h50;
        w[2] = mkw(3'b001, 1'b0, 3'd1, 8'h40, 8'h50); c[2] = 8'hFD; xs[2] = 8'h50;
        w[3] = mkw(3'b001, 1'b0, 3'd7, 8'h9C, 8'h5A); c[3] = 8'h80; xs[3] = 8'h9C;
        w[4] = mkw(3'b001, 1'b1, 3'd5, 8'h33, 8'h21); c[4] = 8'h20; xs[4] = 8'h21;
        for (int i = 0; i < 5; i++) begin
            drive(w[i], c[i], 8'($urandom), 1'b0, 1'b0, ex(xs[i], 3'd0, 1'b0, 1'b0), "two_way");
            e = sb.pop_front();
            checks++;
            if ({state, depth, ovf, unf} !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i,
                         {state, depth, ovf, unf}, e.v);
            end
        end
    endtask

    task automatic test_nesting();
        exp_t e;
        drive(mkw(3'b010, 1'b0, 3'd0, 8'h00, 8'h10), 8'($urandom), 8'($urandom),
              1'b0, 1'b0, ex(8'h10, 3'd0, 1'b0, 1'b0), "jump_to_10");
        for (int k = 0; k < 5; k++) begin
            drive(mkw(3'b110, 1'b0, 3'd0, 8'($urandom), 8'(8'h11 + k)), 8'($urandom), 8'($urandom),
                  1'b0, 1'b0, ex(8'(8'h11 + k), (k < 4) ? 3'(k + 1) : 3'd4, (k == 4), 1'b0),
                  "call_nest");
        end
        for (int j = 0; j < 5; j++) begin
            drive(mkw(3'b111, 1'b0, 3'd0, 8'($urandom), 8'($urandom)), 8'($urandom), 8'($urandom),
                  1'b0, 1'b0, ex((j < 4) ? 8'(8'h14 - j) : 8'h01, (j < 4) ? 3'(3 - j) : 3'd0,
                  1'b1, (j == 4)), "return_nest");
        end
        // Each queued expectation belongs to one edge; drive already waited for it.
        for (int i = 0; i < 11; i++) begin
            e = sb.pop_front();
            checks++;
            if (e.name == "jump_to_10") continue;
            checks--;
        end
    endtask

    task automatic test_halt();
        exp_t        e;
        logic [63:0] w  [9];
        logic        h  [9];
        logic        r  [9];
        logic [12:0] xs [9];
        w[0] = mkw(3'b110, 1'b0, 3'd0, 8'h00, 8'h60); h[0] = 1'b1; r[0] = 1'b1; xs[0] = ex(8'h00, 3'd0, 1'b0, 1'b0);
        w[1] = mkw(3'b110, 1'b0, 3'd0, 8'h00, 8'h30); h[1] = 1'b0; r[1] = 1'b0; xs[1] = ex(8'h30, 3'd1, 1'b0, 1'b0);
        for (int i = 2; i < 6; i++) begin
            w[i] = mkw(3'b110, 1'b0, 3'd0, 8'h00, 8'h60); h[i] = 1'b1; r[i] = 1'b0;
            xs[i] = ex(8'h30, 3'd1, 1'b0, 1'b0);
        end
        w[6] = mkw(3'b111, 1'b0, 3'd0, 8'h00, 8'h00); h[6] = 1'b0; r[6] = 1'b0; xs[6] = ex(8'h01, 3'd0, 1'b0, 1'b0);
        w[7] = mkw(3'b110, 1'b0, 3'd0, 8'h00, 8'h30); h[7] = 1'b0; r[7] = 1'b0; xs[7] = ex(8'h30, 3'd1, 1'b0, 1'b0);
        w[8] = mkw(3'b110, 1'b0, 3'd0, 8'h00, 8'h60); h[8] = 1'b1; r[8] = 1'b1; xs[8] = ex(8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(w[i], 8'($urandom), 8'($urandom), h[i], r[i], xs[i], "halt_reset");
            e = sb.pop_front();
            checks++;
            if ({state, depth, ovf, unf} !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i,
                         {state, depth, ovf, unf}, e.v);
            end
        end
        drive(mkw(3'b111, 1'b0, 3'd0, 8'h00, 8'h00), 8'($urandom), 8'($urandom), 1'b0, 1'b0,
              ex(8'h01, 3'd0, 1'b0, 1'b1), "return_after_reset");
        e = sb.pop_front();
        checks++;
        if ({state, depth, ovf, unf} !== e.v) begin
            failures++;
            $display("FAIL %s: got %h want %h", e.name, {state, depth, ovf, unf}, e.v);
        end
    endtask

    initial begin
        reset     = 1'b1;
        halt      = 1'b0;
        cond      = '0;
        enc_state = '0;
        rom_word  = '0;
        test_reset();
        test_moc_wait();
        test_dispatch_wrap();
        test_two_way();
        test_nesting_checked();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Nested calls/returns compared edge by edge against the LIFO expectations.
    task automatic test_nesting_checked();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) begin
                drive(mkw(3'b010, 1'b0, 3'd0, 8'h00, 8'h10), 8'($urandom), 8'($urandom),
                      1'b0, 1'b0, ex(8'h10, 3'd0, 1'b0, 1'b0), "jump_to_10");
            end else if (i < 6) begin
                drive(mkw(3'b110, 1'b0, 3'd0, 8'($urandom), 8'(8'h10 + i)), 8'($urandom),
                      8'($urandom), 1'b0, 1'b0,
                      ex(8'(8'h10 + i), (i < 5) ? 3'(i) : 3'd4, (i == 5), 1'b0), "call_nest");
            end else begin
                drive(mkw(3'b111, 1'b0, 3'd0, 8'($urandom), 8'($urandom)), 8'($urandom),
                      8'($urandom), 1'b0, 1'b0,
                      ex((i < 10) ? 8'(8'h1A - i) : 8'h01, (i < 10) ? 3'(9 - i) : 3'd0,
                         1'b1, (i == 10)), "return_nest");
            end
            e = sb.pop_front();
            checks++;
            if ({state, depth, ovf, unf} !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got %h want %h", e.name, i,
                         {state, depth, ovf, unf}, e.v);
            end
        end
    endtask

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port rom_word, input, 64 bits: current control word from the control ROM, combinational from state.
REQ-004 SHALL have port enc_state, input, 8 bits: dispatch address from the instruction encoder.
REQ-005 SHALL have port cond, input, 8 bits: condition inputs. Bit 0 = MOC; bit 1 = condition-tester result; bits 7:2 are general-purpose.
REQ-006 SHALL have port halt, input, 1 bit: freezes sequencing when high.
REQ-007 SHALL have port state, output, 8 bits: registered current microstate, drives the ROM address.
REQ-008 SHALL have port depth, output, 3 bits: number of return-stack entries, 0..4.
REQ-009 SHALL have port ovf, output, 1 bit: sticky return-stack overflow flag.
REQ-010 SHALL have port unf, output, 1 bit: sticky return-stack underflow flag.

Function
REQ-011 SHALL decode rom_word fields as follows: N = rom_word[56:54]; INV = rom_word[53]; S = rom_word[50:48]; CRH = rom_word[15:8]; CRL = rom_word[7:0]. All other bits SHALL be ignored.
REQ-012 SHALL compute the test bit C = cond[S] XOR INV.
REQ-013 SHALL compute the incremented state, inc = state + 1, modulo 256; 255 wraps to 0.
REQ-014 SHALL select next state by N:
- 000: next = 1 (fetch vector).
- 001: next = C ? CRH : CRL (two-way branch).
- 010: next = CRL (unconditional jump).
- 011: next = inc.
- 100: next = enc_state (dispatch).
- 101: next = C ? CRL : inc (conditional branch).
- 110: call. Push inc, then next = CRL.
- 111: return. Pop the top entry; next = popped value.
REQ-015 SHALL register next into state on every rising clk edge where reset=0 and halt=0; the result is visible in the following cycle (one-cycle latency).
REQ-016 SHALL hold state, the stack, depth, ovf and unf unchanged while halt=1 and reset=0.
REQ-017 SHALL implement the return stack as a 4-entry LIFO, 8 bits per entry.
REQ-018 On a call with depth=4: SHALL NOT modify the stack, SHALL still jump to CRL, and SHALL set ovf.
REQ-019 On a return with depth=0: SHALL set next = 1, SHALL leave depth at 0, and SHALL set unf.
REQ-020 Once set, ovf and unf SHALL remain 1 until reset.
REQ-021 SHALL increment depth on a successful push, decrement it on a successful pop, and leave it unchanged otherwise.
REQ-022 SHALL read no combinational path from any output back into rom_word inside this block; the only path from state to rom_word is through the external ROM.

Reset
REQ-023 On a rising clk edge with reset=1: state=0, depth=0, ovf=0, unf=0, and all stack entries cleared to 0.
REQ-024 reset SHALL take priority over halt and over any N code present in the same cycle.
REQ-025 reset asserted mid-sequence (for example during a subroutine) SHALL discard all stack contents.
REQ-026 After reset deasserts, the first sequencing edge SHALL act on rom_word of state 0.

Verification
REQ-027 Reset release: reset 1 for 2 cycles, then 0, with rom_word N=000 -> state=0 during reset; one edge later state=1; depth=0, ovf=0, unf=0.
REQ-028 MOC wait loop: state=3, N=101, S=0, INV=1, CRL=3, cond[0]=0 for 3 cycles then 1 -> state stays 3 for 3 edges, then becomes 4.
REQ-029 Dispatch and wrap:
- At state=4, N=100 with enc_state=0x2A -> state=0x2A.
- At state=255, N=011 -> state=0.
REQ-030 Subroutine nesting: 5 consecutive calls from states 0x10..0x14 (CRL=0x10+k+1 for call k), then 5 returns -> depth reads 1,2,3,4,4; ovf=1 after the 5th call. The returns yield 0x14,0x13,0x12,0x11, then state=1 with unf=1 on the 5th return.
REQ-031 Two-way branch: N=001, S=1, INV=0, CRH=0x40, CRL=0x50:
- cond[1]=1 -> state=0x40.
- Repeated with INV=1 -> state=0x50.
REQ-032 Halt and simultaneous events:
- halt=1 with N=110 pending -> state and depth unchanged for 4 cycles.
- reset=1 together with halt=1 and N=110 -> state=0, depth=0.
